// File: rtl/breakout_pkg.sv
// Shared breakout definitions: coordinate/colour widths, render states and
// default playfield geometry used by the ball mover and ball renderer.
package breakout_pkg;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned COLOUR_W = 3;
    localparam int unsigned SCAN_W   = 4;

    localparam int unsigned BALL_SIZE_DEFAULT = 4;
    localparam int unsigned SCREEN_W_DEFAULT  = 160;
    localparam int unsigned SCREEN_H_DEFAULT  = 120;

    typedef enum logic [1:0] {
        IDLE,
        ERASE,
        DRAW,
        DONE
    } render_state_t;

endpackage

// File: rtl/ball_render_square_scanner.sv
// Row-major px/py scanner over a BALL_SIZE x BALL_SIZE square; shared by the
// erase and draw phases of ball_render.
module square_scanner
    import breakout_pkg::*;
#(
    parameter int unsigned BALL_SIZE = BALL_SIZE_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              advance,
    output logic [SCAN_W-1:0] px,
    output logic [SCAN_W-1:0] py,
    output logic              last
);

    localparam logic [SCAN_W-1:0] LAST_IDX = SCAN_W'(BALL_SIZE - 1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            px <= '0;
            py <= '0;
        end else if (start) begin
            px <= '0;
            py <= '0;
        end else if (advance) begin
            if (px == LAST_IDX) begin
                px <= '0;
                py <= (py == LAST_IDX) ? '0 : py + 1'b1;
            end else begin
                px <= px + 1'b1;
            end
        end
    end

    assign last = (px == LAST_IDX) && (py == LAST_IDX);

endmodule

// File: rtl/ball_render.sv
// Ball renderer: per accepted position, erases the old square then draws the new one.
// Optional erase phase enabled by defining BALL_RENDER_ERASE_EN.
module ball_render
    import breakout_pkg::*;
#(
    parameter int unsigned          BALL_SIZE   = BALL_SIZE_DEFAULT,
    parameter int unsigned          SCREEN_W    = SCREEN_W_DEFAULT,
    parameter int unsigned          SCREEN_H    = SCREEN_H_DEFAULT,
    parameter logic [COLOUR_W-1:0]  BALL_COLOUR = 3'b111,
    parameter logic [COLOUR_W-1:0]  BG_COLOUR   = 3'b000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [COORD_W-1:0]  pos_x,
    input  logic [COORD_W-1:0]  pos_y,
    input  logic                pos_valid,
    output logic                pos_ready,
    output logic [COORD_W-1:0]  vga_x,
    output logic [COORD_W-1:0]  vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                done
);

    localparam logic [COORD_W:0] LIM_X = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0] LIM_Y = (COORD_W+1)'(SCREEN_H);

    render_state_t       state, next_state;
    logic [COORD_W-1:0]  new_x, new_y;
`ifdef BALL_RENDER_ERASE_EN
    logic [COORD_W-1:0]  old_x, old_y;
    logic                old_valid;
`endif

    logic                accept;
    logic                scan_start, scan_adv, scan_last, active;
    logic [SCAN_W-1:0]   px, py;
    logic [COORD_W-1:0]  base_x, base_y;
    logic [COLOUR_W-1:0] colour;
    logic [COORD_W:0]    sx, sy;

    square_scanner #(.BALL_SIZE(BALL_SIZE)) u_scan (
        .clk     (clk),
        .resetn  (resetn),
        .start   (scan_start),
        .advance (scan_adv),
        .px      (px),
        .py      (py),
        .last    (scan_last)
    );

    assign accept = pos_valid && pos_ready;

    always_comb begin
        next_state = state;
        scan_start = 1'b0;
        scan_adv   = 1'b0;
        active     = 1'b0;
        base_x     = new_x;
        base_y     = new_y;
        colour     = BALL_COLOUR;
        case (state)
            IDLE: begin
                if (accept) begin
                    scan_start = 1'b1;
`ifdef BALL_RENDER_ERASE_EN
                    next_state = old_valid ? ERASE : DRAW;
`else
                    next_state = DRAW;
`endif
                end
            end
`ifdef BALL_RENDER_ERASE_EN
            ERASE: begin
                active = 1'b1;
                base_x = old_x;
                base_y = old_y;
                colour = BG_COLOUR;
                if (scan_last) begin
                    next_state = DRAW;
                    scan_start = 1'b1;
                end else begin
                    scan_adv = 1'b1;
                end
            end
`endif
            DRAW: begin
                active = 1'b1;
                if (scan_last) next_state = DONE;
                else           scan_adv   = 1'b1;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // 11-bit sums so off-screen pixels clip instead of wrapping to the left/top edge.
    assign sx = {1'b0, base_x} + (COORD_W+1)'(px);
    assign sy = {1'b0, base_y} + (COORD_W+1)'(py);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            new_x      <= '0;
            new_y      <= '0;
            pos_ready  <= 1'b1;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= BG_COLOUR;
            vga_plot   <= 1'b0;
            done       <= 1'b0;
        end else begin
            state     <= next_state;
            pos_ready <= (state == IDLE) && !accept;
            done      <= (state == DONE);
            vga_plot  <= active && (sx < LIM_X) && (sy < LIM_Y);
            if (active) begin
                vga_x      <= sx[COORD_W-1:0];
                vga_y      <= sy[COORD_W-1:0];
                vga_colour <= colour;
            end
            if (accept) begin
                new_x <= pos_x;
                new_y <= pos_y;
            end
        end
    end

`ifdef BALL_RENDER_ERASE_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            old_x     <= '0;
            old_y     <= '0;
            old_valid <= 1'b0;
        end else if (state == DRAW && scan_last) begin
            old_x     <= new_x;
            old_y     <= new_y;
            old_valid <= 1'b1;
        end
    end
`endif

endmodule
